// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state encoding and default width for alu_muldiv.
package alu_pkg;
    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_MIN   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MFHI  = 4'd9;
    localparam logic [3:0] OP_MFLO  = 4'd10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_FIX  = 2'd3;
endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply/divide datapath, one bit per cycle for WIDTH cycles.
// Divide path present only when ALU_MULDIV_DIV_EN is defined.
module muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
`ifdef ALU_MULDIV_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    // acc holds the product high half / running remainder; x the multiplier / quotient
    logic             run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q;
    logic [WIDTH:0]   sum;
`ifdef ALU_MULDIV_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   shl, diff;
`endif

    always_comb begin
        sum   = {1'b0, acc_q} + (x_q[0] ? {1'b0, y_q} : '0);
        acc_d = sum[WIDTH:1];
        x_d   = {sum[0], x_q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        shl  = {acc_q, x_q[WIDTH-1]};
        diff = shl - {1'b0, y_q};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shl[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
`ifdef ALU_MULDIV_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CW'(WIDTH - 1);
            acc_q <= '0;
            x_q   <= a_i;
            y_q   <= b_i;
`ifdef ALU_MULDIV_DIV_EN
            div_q <= is_div_i;
`endif
        end else if (run_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) run_q <= 1'b0;
        end
    end

    assign last_o = run_q && (cnt_q == '0);
    assign hi_o   = acc_q;
    assign lo_o   = x_q;
endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith ops and an iterative MUL/DIV unit writing HI/LO.
// Define ALU_MULDIV_DIV_EN to build DIV/DIVU; otherwise ops 5 and 8 are unsupported.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             op_err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    state_t             state_q, state_d;
    logic               accept, is_mul, is_dv, is_sgn, a_neg, b_neg, sc_ok, core_last;
    logic [WIDTH-1:0]   a_mag, b_mag, sc_res, fix_hi, fix_lo, core_hi, core_lo;
    logic [2*WIDTH-1:0] prod;
    logic               out_valid_q, zero_q, op_err_q, neg_a_q, neg_b_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
`ifdef ALU_MULDIV_DIV_EN
    logic               div_q, b_zero_q;
    logic [WIDTH-1:0]   a_q;
`endif

    assign busy     = (state_q != ST_IDLE);
    assign in_ready = !busy;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_MULDIV_DIV_EN
    assign is_dv    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_sgn   = (op == OP_MULT) || (op == OP_DIV);
`else
    assign is_dv    = 1'b0;
    assign is_sgn   = (op == OP_MULT);
`endif
    // The core works on magnitudes; signs are re-applied in FIX
    assign a_neg = is_sgn && src_a[WIDTH-1];
    assign b_neg = is_sgn && src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    always_comb begin
        sc_ok  = 1'b1;
        sc_res = '0;
        case (op)
            OP_AND:  sc_res = src_a & src_b;
            OP_OR:   sc_res = src_a | src_b;
            OP_ADD:  sc_res = src_a + src_b;
            OP_SUB:  sc_res = src_a - src_b;
            OP_MIN:  sc_res = (src_a < src_b) ? src_a : src_b;
            OP_MFHI: sc_res = hi_q;
            OP_MFLO: sc_res = lo_q;
            default: sc_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) state_d = ST_MUL;
`ifdef ALU_MULDIV_DIV_EN
                else if (accept && is_dv) state_d = ST_DIV;
`endif
            end
            ST_MUL: if (core_last) state_d = ST_FIX;
`ifdef ALU_MULDIV_DIV_EN
            ST_DIV: if (core_last) state_d = ST_FIX;
`endif
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prod = {core_hi, core_lo};
        if (neg_a_q ^ neg_b_q) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
        if (div_q) begin
            if (b_zero_q) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = (neg_a_q ^ neg_b_q) ? -core_lo : core_lo;
                fix_hi = neg_a_q ? -core_hi : core_hi;
            end
        end
`endif
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (accept && (is_mul || is_dv)),
`ifdef ALU_MULDIV_DIV_EN
        .is_div_i (is_dv),
`endif
        .a_i      (a_mag),
        .b_i      (b_mag),
        .last_o   (core_last),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            op_err_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            div_q       <= 1'b0;
            b_zero_q    <= 1'b0;
            a_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            if (accept) begin
                if (is_mul || is_dv) begin
                    neg_a_q <= a_neg;
                    neg_b_q <= b_neg;
`ifdef ALU_MULDIV_DIV_EN
                    div_q    <= is_dv;
                    b_zero_q <= (src_b == '0);
                    a_q      <= src_a;
`endif
                end else begin
                    out_valid_q <= 1'b1;
                    result_q    <= sc_res;
                    zero_q      <= (sc_res == '0);
                    op_err_q    <= !sc_ok;
                end
            end
            if (state_q == ST_FIX) begin
                hi_q        <= fix_hi;
                lo_q        <= fix_lo;
                result_q    <= fix_lo;
                zero_q      <= (fix_lo == '0);
                op_err_q    <= 1'b0;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign op_err    = op_err_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule
